tick_divider_mc: RTL
====================

# tick_divider_mc

Multi-channel programmable event divider for game timing (alien march, bullet step, animation and sound pacing). Each channel counts qualified enable events and emits a one-cycle tick every N events, in periodic or one-shot mode. N can be reloaded per channel at runtime. One instance replaces the per-object single-purpose tick counters and sits between the frame/second-rate strobe sources and the game FSMs.

## Interface
Parameters:
- NCH, 4: number of independent channels (1..16)
- WIDTH, 8: counter and divisor width in bits (2..32)
- RST_DIV, 1: divisor loaded into every channel at reset (must fit WIDTH, nonzero)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- Rst  in  1  asynchronous, active-low reset
- Sm  in  NCH  per-channel count-enable event, one event per cycle high
- pause  in  1  global freeze: no counting, no ticks while high
- ld  in  NCH  per-channel load strobe
- div_in  in  NCH*WIDTH  divisor per channel, channel i at bits [i*WIDTH +: WIDTH], sampled on ld[i]
- oneshot  in  NCH  mode per channel, sampled on ld[i] (1 = one-shot, 0 = periodic)
- clr  in  NCH  per-channel synchronous counter clear
- M  out  NCH  tick, registered, one cycle wide
- armed  out  NCH  channel is counting-capable (not expired one-shot, divisor nonzero)
- cnt_o  out  NCH*WIDTH  current count per channel, same packing as div_in

## Operation
Per-channel state: cnt (WIDTH), div (WIDTH), mode (1), arm (1), tick register.
- Reset (Rst=0, async): cnt=0, div=RST_DIV, mode=periodic, arm=1, M=0. Therefore armed=1 and cnt_o=0.
- Priority per channel, per cycle: ld > clr > pause > count.
- ld[i]: div=div_in slice, mode=oneshot[i], cnt=0, arm=1, M[i]=0 next cycle. Any coincident Sm[i] is ignored.
- clr[i] (no ld): cnt=0, M[i]=0. Div, mode and arm are unchanged. A coincident Sm[i] is ignored.
- pause=1 (no ld/clr): cnt holds, M=0.
- Count: if Sm[i] and arm and div!=0:
  - if cnt == div-1: cnt=0, M[i]=1 next cycle, and arm=0 if mode=one-shot.
  - otherwise cnt=cnt+1.
- Otherwise cnt holds and M[i]=0.
- div=0: channel is inert. cnt holds 0, no ticks, armed=0.
- div=1: tick on every Sm event (the legacy single-event behaviour, which is the default).
- Expired one-shot: arm=0, Sm ignored, cnt=0, until the next ld[i].
- Width: cnt compares against div-1 in WIDTH bits. cnt never exceeds div-1, so there is no wrap. div=2^WIDTH-1 is the maximum period.
- Channels are fully independent. Only pause is shared.

## Timing
- Latency: the Sm event that completes the period raises M on the following cycle, for exactly one cycle.
- Back-to-back: with div=1 and Sm held high, M is high every cycle after the first.
- armed and cnt_o are registered-state combinational views, updated the cycle after the causing edge.
- A ld in the same cycle as a terminal event suppresses that tick.
- Reset asserted mid-count clears immediately, independent of CLK. On deassertion the first count occurs on the first edge with Sm high.

## Structure
- A shared package holds localparam defaults (NCH, WIDTH, RST_DIV) and the mode encoding constants (MODE_PERIODIC=0, MODE_ONESHOT=1).
- Sub-module tick_div_chan implements one channel (cnt, div, mode, arm, tick flop). The top instantiates NCH copies with a generate loop and packs/unpacks the flat buses.
- No other hierarchy.

## Test plan
- Reset defaults: hold Rst=0, then release; Sm[0]=1 continuously → M[0] high every cycle starting the cycle after the first Sm edge; armed=all ones; cnt_o=0.
- Periodic divide: ld[1] with div=5, oneshot=0; apply 12 Sm[1] pulses with gaps → M[1] pulses after the 5th and 10th events only; cnt_o[1]=2 at the end.
- One-shot: ld[2] with div=3, oneshot=1; apply 7 events → exactly one M[2] pulse after the 3rd event; armed[2]=0 afterwards; reload → counts again.
- Pause/clr: channel at cnt=3 (div=5); pause 4 cycles with Sm high → cnt stays 3, no M; clr[0] with Sm → cnt=0, no M.
- Priority/boundaries: ld coinciding with a terminal Sm → no tick and cnt=0; div=0 → armed=0 and no ticks over 20 events; WIDTH=8, div=255 → tick after exactly 255 events.
- Async reset mid-count: drop Rst between clock edges at cnt=4 → cnt_o, M cleared before the next edge; div returns to RST_DIV.

Source files
------------

// File: rtl/tick_divider_mc_pkg.sv
// Shared defaults and mode encoding for the multi-channel tick divider.
package tick_divider_mc_pkg;

    localparam int unsigned DEF_NCH     = 4;
    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_RST_DIV = 1;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_div_chan.sv
// One divider channel: counts qualified events, ticks every div events,
// and optionally disarms itself after the first tick (one-shot).
module tick_div_chan
    import tick_divider_mc_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned RST_DIV = DEF_RST_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sm,
    input  logic             i_pause,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_oneshot,
    input  logic             i_clr,
    output logic             o_tick,
    output logic             o_armed_c,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt, w_cnt;
    logic [WIDTH-1:0] r_div, w_div;
    logic             r_mode, w_mode;
    logic             r_arm, w_arm;
    logic             r_tick, w_tick;
    logic             w_div_nz;
    logic             w_term;

    assign w_div_nz = (r_div != '0);
    assign w_term   = (r_cnt == WIDTH'(r_div - WIDTH'(1)));

    // Priority: load, clear, pause, count.
    always_comb begin
        w_cnt  = r_cnt;
        w_div  = r_div;
        w_mode = r_mode;
        w_arm  = r_arm;
        w_tick = 1'b0;
        if (i_ld) begin
            w_div  = i_div;
            w_mode = i_oneshot;
            w_cnt  = '0;
            w_arm  = 1'b1;
        end else if (i_clr) begin
            w_cnt = '0;
        end else if (!i_pause && i_sm && r_arm && w_div_nz) begin
            if (w_term) begin
                w_cnt  = '0;
                w_tick = 1'b1;
                if (r_mode == MODE_ONESHOT) begin
                    w_arm = 1'b0;
                end
            end else begin
                w_cnt = WIDTH'(r_cnt + WIDTH'(1));
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_div  <= WIDTH'(RST_DIV);
            r_mode <= MODE_PERIODIC;
            r_arm  <= 1'b1;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt;
            r_div  <= w_div;
            r_mode <= w_mode;
            r_arm  <= w_arm;
            r_tick <= w_tick;
        end
    end

    assign o_tick    = r_tick;
    assign o_armed_c = r_arm & w_div_nz;
    assign o_cnt     = r_cnt;

endmodule

// File: rtl/tick_divider_mc.sv
// Multi-channel programmable event divider; NCH independent channels
// sharing only the global pause.
module tick_divider_mc
    import tick_divider_mc_pkg::*;
#(
    parameter int unsigned NCH     = DEF_NCH,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned RST_DIV = DEF_RST_DIV
) (
    input  logic                 CLK,
    input  logic                 Rst,
    input  logic [NCH-1:0]       Sm,
    input  logic                 pause,
    input  logic [NCH-1:0]       ld,
    input  logic [NCH*WIDTH-1:0] div_in,
    input  logic [NCH-1:0]       oneshot,
    input  logic [NCH-1:0]       clr,
    output logic [NCH-1:0]       M,
    output logic [NCH-1:0]       armed,
    output logic [NCH*WIDTH-1:0] cnt_o
);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        tick_div_chan #(
            .WIDTH   (WIDTH),
            .RST_DIV (RST_DIV)
        ) u_chan (
            .i_clk     (CLK),
            .i_rst_n   (Rst),
            .i_sm      (Sm[gi]),
            .i_pause   (pause),
            .i_ld      (ld[gi]),
            .i_div     (div_in[gi*WIDTH +: WIDTH]),
            .i_oneshot (oneshot[gi]),
            .i_clr     (clr[gi]),
            .o_tick    (M[gi]),
            .o_armed_c (armed[gi]),
            .o_cnt     (cnt_o[gi*WIDTH +: WIDTH])
        );
    end

endmodule
